// File: rtl/fmap_ram_sequencer_if.sv
// Requester-side bundle of the feature-map RAM sequencer: write, read and clear
// handshakes plus status. The requester side is master; the sequencer is slave.
interface fmap_ram_sequencer_if #(
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned PARA_Y           = 3,
   parameter int unsigned WRITE_ADDR_WIDTH = 3,
   parameter int unsigned READ_ADDR_WIDTH  = 3
);
   localparam int unsigned WORD_W = PARA_Y * DATA_WIDTH;

   logic                        wr_valid;
   logic                        wr_ready;
   logic                        wr_acc;
   logic [WRITE_ADDR_WIDTH-1:0] wr_addr;
   logic [WORD_W-1:0]           wr_data;

   logic                        rd_valid;
   logic                        rd_ready;
   logic [READ_ADDR_WIDTH-1:0]  rd_addr;
   logic [READ_ADDR_WIDTH-1:0]  rd_sub_addr;
   logic                        rd_data_valid;
   logic [WORD_W-1:0]           rd_data;

   logic                        clr_start;
   logic                        clr_busy;
   logic                        acc_err;

   modport master (
      output wr_valid, wr_acc, wr_addr, wr_data,
      output rd_valid, rd_addr, rd_sub_addr,
      output clr_start,
      input  wr_ready, rd_ready, rd_data_valid, rd_data, clr_busy, acc_err
   );

   modport slave (
      input  wr_valid, wr_acc, wr_addr, wr_data,
      input  rd_valid, rd_addr, rd_sub_addr,
      input  clr_start,
      output wr_ready, rd_ready, rd_data_valid, rd_data, clr_busy, acc_err
   );
endinterface

// File: rtl/fmap_ram_sequencer.sv
// Serialises writes, accumulates, reads and bank clears onto one PARA_Y-wide
// float16 feature-map RAM bank; exactly one RAM operation is in flight at a time.
module fmap_ram_sequencer #(
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned PARA_Y           = 3,
   parameter int unsigned WRITE_ADDR_WIDTH = 3,
   parameter int unsigned READ_ADDR_WIDTH  = 3,
   parameter int unsigned ROW_COUNT        = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   fmap_ram_sequencer_if.slave           req,
   output logic                          ram_ena_w,
   output logic                          ram_ena_add_write,
   output logic [WRITE_ADDR_WIDTH-1:0]   ram_addr_write,
   output logic [PARA_Y*DATA_WIDTH-1:0]  ram_din,
   input  logic                          ram_write_ready,
   output logic                          ram_ena_r,
   output logic [READ_ADDR_WIDTH-1:0]    ram_addr_read,
   output logic [READ_ADDR_WIDTH-1:0]    ram_sub_addr_read,
   input  logic [PARA_Y*DATA_WIDTH-1:0]  ram_dout
);

   localparam int unsigned WORD_W = PARA_Y * DATA_WIDTH;
   localparam logic [WRITE_ADDR_WIDTH-1:0] LAST_ROW = WRITE_ADDR_WIDTH'(ROW_COUNT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WR     = 3'd1;
   localparam logic [2:0] S_ACC1   = 3'd2;
   localparam logic [2:0] S_ACC2   = 3'd3;
   localparam logic [2:0] S_ACCCHK = 3'd4;
   localparam logic [2:0] S_RD     = 3'd5;
   localparam logic [2:0] S_RDCAP  = 3'd6;
   localparam logic [2:0] S_CLR    = 3'd7;

   localparam logic RR_WR = 1'b0;
   localparam logic RR_RD = 1'b1;

   logic [2:0]                  state,      state_nxt;
   logic                        rr_last,    rr_last_nxt;
   logic                        clr_pend,   clr_pend_nxt;
   logic [WRITE_ADDR_WIDTH-1:0] clr_row,    clr_row_nxt;
   logic                        ena_w_q,    ena_w_nxt;
   logic                        ena_add_q,  ena_add_nxt;
   logic                        ena_r_q,    ena_r_nxt;
   logic [WRITE_ADDR_WIDTH-1:0] waddr_q,    waddr_nxt;
   logic [WORD_W-1:0]           din_q,      din_nxt;
   logic [READ_ADDR_WIDTH-1:0]  raddr_q,    raddr_nxt;
   logic [READ_ADDR_WIDTH-1:0]  rsub_q,     rsub_nxt;
   logic                        rdv_q,      rdv_nxt;
   logic [WORD_W-1:0]           rdata_q,    rdata_nxt;
   logic                        err_q,      err_nxt;
   logic                        busy_q,     busy_nxt;

   logic idle_free_c;
   logic pick_wr_c;
   logic wr_fire_c;
   logic rd_fire_c;

   // A pending or same-cycle clear blocks both data requesters.
   assign idle_free_c = (state == S_IDLE) && !busy_q && !req.clr_start && !clr_pend;

   // Round-robin: the class not served last wins a tie; a lone requester always wins.
   assign pick_wr_c = req.wr_valid ? ((rr_last == RR_RD) || !req.rd_valid)
                                   : ((rr_last == RR_RD) && !req.rd_valid);

   assign req.wr_ready = idle_free_c && pick_wr_c;
   assign req.rd_ready = idle_free_c && !pick_wr_c;
   assign wr_fire_c    = req.wr_valid && req.wr_ready;
   assign rd_fire_c    = req.rd_valid && req.rd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_last   <= RR_RD;
         clr_pend  <= 1'b0;
         clr_row   <= '0;
         ena_w_q   <= 1'b0;
         ena_add_q <= 1'b0;
         ena_r_q   <= 1'b0;
         waddr_q   <= '0;
         din_q     <= '0;
         raddr_q   <= '0;
         rsub_q    <= '0;
         rdv_q     <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_last   <= rr_last_nxt;
         clr_pend  <= clr_pend_nxt;
         clr_row   <= clr_row_nxt;
         ena_w_q   <= ena_w_nxt;
         ena_add_q <= ena_add_nxt;
         ena_r_q   <= ena_r_nxt;
         waddr_q   <= waddr_nxt;
         din_q     <= din_nxt;
         raddr_q   <= raddr_nxt;
         rsub_q    <= rsub_nxt;
         rdv_q     <= rdv_nxt;
         rdata_q   <= rdata_nxt;
         err_q     <= err_nxt;
         busy_q    <= busy_nxt;
      end
   end

   // Next state plus next values of every registered output, so RAM controls
   // line up with the state they belong to.
   always_comb begin
      state_nxt    = state;
      rr_last_nxt  = rr_last;
      clr_pend_nxt = clr_pend;
      clr_row_nxt  = clr_row;
      ena_w_nxt    = 1'b0;
      ena_add_nxt  = 1'b0;
      ena_r_nxt    = 1'b0;
      waddr_nxt    = waddr_q;
      din_nxt      = din_q;
      raddr_nxt    = raddr_q;
      rsub_nxt     = rsub_q;
      rdv_nxt      = 1'b0;
      rdata_nxt    = rdata_q;
      err_nxt      = err_q;

      // Clears arriving mid-operation are queued; those during a clear are dropped.
      if (req.clr_start && (state != S_IDLE) && !busy_q) begin
         clr_pend_nxt = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (req.clr_start || clr_pend) begin
               state_nxt    = S_CLR;
               clr_pend_nxt = 1'b0;
               clr_row_nxt  = '0;
               ena_w_nxt    = 1'b1;
               waddr_nxt    = '0;
               din_nxt      = '0;
            end else if (wr_fire_c) begin
               rr_last_nxt = RR_WR;
               ena_w_nxt   = 1'b1;
               ena_add_nxt = req.wr_acc;
               waddr_nxt   = req.wr_addr;
               din_nxt     = req.wr_data;
               state_nxt   = req.wr_acc ? S_ACC1 : S_WR;
            end else if (rd_fire_c) begin
               rr_last_nxt = RR_RD;
               ena_r_nxt   = 1'b1;
               raddr_nxt   = req.rd_addr;
               rsub_nxt    = req.rd_sub_addr;
               state_nxt   = S_RD;
            end
         end
         S_WR: begin
            state_nxt = S_IDLE;
         end
         S_ACC1: begin
            ena_w_nxt   = 1'b1;
            ena_add_nxt = 1'b1;
            state_nxt   = S_ACC2;
         end
         S_ACC2: begin
            state_nxt = S_ACCCHK;
         end
         S_ACCCHK: begin
            if (!ram_write_ready) begin
               err_nxt = 1'b1;
            end
            state_nxt = S_IDLE;
         end
         S_RD: begin
            state_nxt = S_RDCAP;
         end
         S_RDCAP: begin
            rdv_nxt   = 1'b1;
            rdata_nxt = ram_dout;
            state_nxt = S_IDLE;
         end
         S_CLR: begin
            if (clr_row == LAST_ROW) begin
               state_nxt = S_IDLE;
            end else begin
               clr_row_nxt = clr_row + WRITE_ADDR_WIDTH'(1);
               ena_w_nxt   = 1'b1;
               waddr_nxt   = clr_row + WRITE_ADDR_WIDTH'(1);
               din_nxt     = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt == S_CLR);
   end

   assign ram_ena_w          = ena_w_q;
   assign ram_ena_add_write  = ena_add_q;
   assign ram_addr_write     = waddr_q;
   assign ram_din            = din_q;
   assign ram_ena_r          = ena_r_q;
   assign ram_addr_read      = raddr_q;
   assign ram_sub_addr_read  = rsub_q;

   assign req.rd_data_valid  = rdv_q;
   assign req.rd_data        = rdata_q;
   assign req.clr_busy       = busy_q;
   assign req.acc_err        = err_q;

endmodule

// File: tb/tb_fmap_ram_sequencer.sv
// Directed bench for fmap_ram_sequencer with a behavioural float16 RAM bank
// that implements the two-cycle read-add-write protocol.
module tb_fmap_ram_sequencer;
   localparam int unsigned DW  = 16;
   localparam int unsigned PY  = 3;
   localparam int unsigned WAW = 3;
   localparam int unsigned RAW = 3;
   localparam int unsigned RC  = 7;
   localparam int unsigned WW  = PY * DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fmap_ram_sequencer_if #(.DATA_WIDTH(DW), .PARA_Y(PY), .WRITE_ADDR_WIDTH(WAW),
                           .READ_ADDR_WIDTH(RAW)) req_if ();

   logic           ram_ena_w, ram_ena_add_write, ram_ena_r, ram_write_ready;
   logic [WAW-1:0] ram_addr_write;
   logic [RAW-1:0] ram_addr_read, ram_sub_addr_read;
   logic [WW-1:0]  ram_din, ram_dout;

   fmap_ram_sequencer #(.DATA_WIDTH(DW), .PARA_Y(PY), .WRITE_ADDR_WIDTH(WAW),
                        .READ_ADDR_WIDTH(RAW), .ROW_COUNT(RC)) dut (
      .clk               (clk),
      .rst               (rst),
      .req               (req_if.slave),
      .ram_ena_w         (ram_ena_w),
      .ram_ena_add_write (ram_ena_add_write),
      .ram_addr_write    (ram_addr_write),
      .ram_din           (ram_din),
      .ram_write_ready   (ram_write_ready),
      .ram_ena_r         (ram_ena_r),
      .ram_addr_read     (ram_addr_read),
      .ram_sub_addr_read (ram_sub_addr_read),
      .ram_dout          (ram_dout)
   );

   // Positive-normal float16 add, enough for the directed operands used here.
   function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
      logic [4:0]  ea, eb, e;
      logic [11:0] ma, mb, m;
      logic [15:0] t;
      if (a[14:10] == 5'd0) return b;
      if (b[14:10] == 5'd0) return a;
      if (a[14:10] < b[14:10]) begin t = a; a = b; b = t; end
      ea = a[14:10]; eb = b[14:10];
      ma = {2'b01, a[9:0]};
      mb = {2'b01, b[9:0]} >> (ea - eb);
      m  = ma + mb;
      e  = ea;
      if (m[11]) begin m = m >> 1; e = e + 5'd1; end
      return {1'b0, e, m[9:0]};
   endfunction

   function automatic logic [WW-1:0] w3(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2);
      return {e2, e1, e0};
   endfunction

   // RAM model: first add-write cycle latches operands, second writes the sum.
   logic [WW-1:0] mem [0:7];
   logic [WW-1:0] op_a, op_b;
   logic          add_prev;
   logic          stall_wr_ready;
   initial for (int i = 0; i < 8; i++) mem[i] = '0;

   always @(posedge clk) begin
      add_prev        <= ram_ena_w & ram_ena_add_write;
      ram_write_ready <= 1'b0;
      if (ram_ena_w && !ram_ena_add_write) begin
         mem[ram_addr_write] <= ram_din;
      end else if (ram_ena_w && ram_ena_add_write && !add_prev) begin
         op_a <= mem[ram_addr_write];
         op_b <= ram_din;
      end else if (ram_ena_w && ram_ena_add_write) begin
         for (int k = 0; k < 3; k++)
            mem[ram_addr_write][k*16 +: 16] <= fp16_add(op_a[k*16 +: 16], op_b[k*16 +: 16]);
         ram_write_ready <= !stall_wr_ready;
      end
      if (ram_ena_r) ram_dout <= mem[ram_addr_read];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input bit is_wr, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (is_wr ? req_if.wr_ready : req_if.rd_ready) begin ok = 1'b1; return; end
         @(negedge clk);
      end
      chk(is_wr ? "wr_ready_timeout" : "rd_ready_timeout", 0, 1);
   endtask

   // Called at a negedge; returns at the negedge of the first IDLE cycle afterwards.
   task automatic do_write(input logic [WAW-1:0] addr, input logic [WW-1:0] data, input logic acc);
      bit ok;
      req_if.wr_valid = 1'b1; req_if.wr_acc = acc;
      req_if.wr_addr  = addr; req_if.wr_data = data;
      wait_ready(1'b1, ok);
      if (!ok) begin req_if.wr_valid = 1'b0; return; end
      @(posedge clk); @(negedge clk);
      req_if.wr_valid = 1'b0;
      chk("wr_ena_w", ram_ena_w, 1);
      chk("wr_add_sel", ram_ena_add_write, acc);
      chk("wr_row", ram_addr_write, addr);
      chk("wr_din", ram_din, data);
      chk("wr_no_rd", ram_ena_r, 0);
      if (acc) begin
         @(negedge clk);
         chk("acc2_ctrl", {ram_ena_w, ram_ena_add_write}, 2'b11);
         @(negedge clk);
         chk("accchk_ctrl", {ram_ena_w, ram_ena_add_write}, 2'b00);
      end
      @(negedge clk);
      chk("wr_end_ena_w", ram_ena_w, 0);
   endtask

   task automatic do_read(input logic [RAW-1:0] addr, input logic [RAW-1:0] sub,
                          input logic [WW-1:0] exp);
      bit ok;
      req_if.rd_valid = 1'b1; req_if.rd_addr = addr; req_if.rd_sub_addr = sub;
      wait_ready(1'b0, ok);
      if (!ok) begin req_if.rd_valid = 1'b0; return; end
      @(posedge clk); @(negedge clk);
      req_if.rd_valid = 1'b0;
      chk("rd_ctrl", {ram_ena_r, ram_ena_w}, 2'b10);
      chk("rd_row", ram_addr_read, addr);
      chk("rd_sub", ram_sub_addr_read, sub);
      @(negedge clk);
      chk("rd_valid_early", req_if.rd_data_valid, 0);
      @(negedge clk);
      chk("rd_valid", req_if.rd_data_valid, 1);
      chk("rd_data", req_if.rd_data, exp);
   endtask

   typedef struct {
      logic [1:0]     op;    // 0 write, 1 accumulate, 2 read
      logic [WAW-1:0] addr;
      logic [RAW-1:0] sub;
      logic [WW-1:0]  data;  // write data or expected read data
   } vec_t;

   vec_t vecs [11];
   logic [WW-1:0] row7;
   logic [3:0]    order;
   int            grants, overlap;
   bit            ok;

   initial begin
      row7 = 48'h1234_5678_0ABC;
      vecs[0]  = '{0, 3'd2, 3'd0, w3(16'h3C00, 16'h4000, 16'h4200)};
      vecs[1]  = '{2, 3'd2, 3'd0, 48'h4200_4000_3C00};
      vecs[2]  = '{0, 3'd1, 3'd0, w3(16'h3C00, 16'h3C00, 16'h3C00)};
      vecs[3]  = '{1, 3'd1, 3'd0, w3(16'h3C00, 16'h3C00, 16'h3C00)};
      vecs[4]  = '{2, 3'd1, 3'd0, w3(16'h4000, 16'h4000, 16'h4000)};
      vecs[5]  = '{1, 3'd1, 3'd0, w3(16'h4000, 16'h4000, 16'h4000)};
      vecs[6]  = '{2, 3'd1, 3'd0, w3(16'h4400, 16'h4400, 16'h4400)};
      vecs[7]  = '{0, 3'd7, 3'd0, row7};
      vecs[8]  = '{2, 3'd7, 3'd2, row7};
      vecs[9]  = '{1, 3'd2, 3'd0, w3(16'h3C00, 16'h3C00, 16'h3C00)};
      vecs[10] = '{2, 3'd2, 3'd0, w3(16'h4000, 16'h4200, 16'h4400)};

      rst = 1'b1; stall_wr_ready = 1'b0;
      req_if.wr_valid = 0; req_if.wr_acc = 0; req_if.wr_addr = '0; req_if.wr_data = '0;
      req_if.rd_valid = 0; req_if.rd_addr = '0; req_if.rd_sub_addr = '0; req_if.clr_start = 0;
      repeat (3) @(negedge clk);
      chk("rst_ram_ctrl", {ram_ena_w, ram_ena_add_write, ram_ena_r}, 0);
      chk("rst_ram_addr", {ram_addr_write, ram_addr_read, ram_sub_addr_read}, 0);
      chk("rst_ram_din", ram_din, 0);
      chk("rst_status", {req_if.rd_data_valid, req_if.clr_busy, req_if.acc_err}, 0);
      chk("rst_rd_data", req_if.rd_data, 0);
      rst = 1'b0; #1;
      chk("idle_ready", {req_if.wr_ready, req_if.rd_ready}, 2'b10);
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         case (vecs[i].op)
            2'd0: do_write(vecs[i].addr, vecs[i].data, 1'b0);
            2'd1: begin
               do_write(vecs[i].addr, vecs[i].data, 1'b1);
               chk("acc_err_clean", req_if.acc_err, 0);
            end
            default: do_read(vecs[i].addr, vecs[i].sub, vecs[i].data);
         endcase
      end

      // Both classes requesting continuously must alternate, starting with write.
      req_if.wr_valid = 1; req_if.wr_acc = 0; req_if.wr_addr = 3'd3;
      req_if.wr_data = w3(16'h3C00, 16'h3C00, 16'h3C00);
      req_if.rd_valid = 1; req_if.rd_addr = 3'd3; req_if.rd_sub_addr = '0;
      grants = 0; overlap = 0; order = '0;
      for (int c = 0; c < 60 && grants < 4; c++) begin
         #1;
         if (ram_ena_w && ram_ena_r) overlap++;
         if (req_if.wr_ready && req_if.rd_ready) overlap++;
         if (req_if.wr_ready)      begin order = {order[2:0], 1'b0}; grants++; end
         else if (req_if.rd_ready) begin order = {order[2:0], 1'b1}; grants++; end
         @(negedge clk);
      end
      req_if.wr_valid = 0; req_if.rd_valid = 0;
      for (int c = 0; c < 4; c++) begin
         #1; if (ram_ena_w && ram_ena_r) overlap++;
         @(negedge clk);
      end
      chk("rr_grants", grants, 4);
      chk("rr_order", order, 4'b0101);
      chk("rr_overlap", overlap, 0);

      // RAM withholds write_ready: sticky error until reset.
      stall_wr_ready = 1'b1;
      do_write(3'd4, w3(16'h3C00, 16'h3C00, 16'h3C00), 1'b1);
      stall_wr_ready = 1'b0;
      chk("acc_err_set", req_if.acc_err, 1);
      do_write(3'd4, w3(16'h3C00, 16'h3C00, 16'h3C00), 1'b0);
      chk("acc_err_sticky", req_if.acc_err, 1);

      // Clear requested during an accumulate is queued and served afterwards.
      req_if.wr_valid = 1; req_if.wr_acc = 1; req_if.wr_addr = 3'd1;
      req_if.wr_data = w3(16'h3C00, 16'h3C00, 16'h3C00);
      wait_ready(1'b1, ok);
      @(posedge clk); @(negedge clk);
      req_if.wr_valid = 0; req_if.clr_start = 1;
      chk("clr_acc1", ram_ena_add_write, 1);
      @(negedge clk);
      req_if.clr_start = 0;
      chk("clr_acc2", {ram_ena_w, ram_ena_add_write, req_if.clr_busy}, 3'b110);
      @(negedge clk);
      chk("clr_accchk", {ram_ena_w, ram_ena_add_write, req_if.clr_busy}, 3'b000);
      @(negedge clk);
      req_if.wr_valid = 1; req_if.wr_acc = 0; req_if.wr_addr = 3'd5; req_if.wr_data = 48'h1111;
      #1;
      chk("clr_pend_block", {req_if.wr_ready, ram_ena_w, req_if.clr_busy}, 3'b000);
      for (int r = 0; r < 7; r++) begin
         @(negedge clk); #1;
         chk("clr_row_ctrl", {ram_ena_w, ram_ena_add_write, ram_ena_r, ram_addr_write},
             {3'b100, 3'(r)});
         chk("clr_row_data", ram_din, 0);
         chk("clr_busy_wr_ready", {req_if.clr_busy, req_if.wr_ready}, 2'b10);
      end
      @(negedge clk); #1;
      chk("clr_done", {req_if.clr_busy, ram_ena_w, req_if.wr_ready}, 3'b001);
      req_if.wr_valid = 0;
      @(negedge clk);
      do_read(3'd1, 3'd0, '0);
      do_read(3'd7, 3'd0, row7);

      // Reset in ACC1 abandons the accumulate and clears the sticky error.
      req_if.wr_valid = 1; req_if.wr_acc = 1; req_if.wr_addr = 3'd2;
      req_if.wr_data = w3(16'h3C00, 16'h3C00, 16'h3C00);
      wait_ready(1'b1, ok);
      @(posedge clk); @(negedge clk);
      req_if.wr_valid = 0; rst = 1;
      chk("rst_acc1_add", ram_ena_add_write, 1);
      @(negedge clk);
      chk("rst_mid_ctrl", {ram_ena_w, ram_ena_add_write, ram_ena_r}, 0);
      chk("rst_mid_err", req_if.acc_err, 0);
      rst = 0; #1;
      chk("rst_mid_idle", {req_if.wr_ready, req_if.rd_ready}, 2'b10);
      @(negedge clk);
      do_write(3'd2, w3(16'h4400, 16'h4200, 16'h4000), 1'b0);
      do_read(3'd2, 3'd1, 48'h4000_4200_4400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/fmap_ram_sequencer.md
Name: fmap_ram_sequencer

Overview:
- Sequences all accesses to one PARA_Y-wide float16 feature-map RAM bank.
- Arbitrates three requesters: the MAC-group partial-sum writer (plain or accumulate), the downstream reader, and a bank-clear command.
- Drives the RAM's write, add-write and read controls, including its two-cycle read-add-write protocol.
- Sits between the MAC array / layer controller and the RAM. Only one RAM operation is in flight at a time.

Parameters:
DATA_WIDTH, 16, float16 element width
PARA_Y, 3, elements per RAM word (MAC count per group)
WRITE_ADDR_WIDTH, 3, write row address width
READ_ADDR_WIDTH, 3, read row and sub-address width
ROW_COUNT, 7, rows swept by clear (rows 0..ROW_COUNT-1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_acc  in  1  0: overwrite row; 1: accumulate into row
wr_addr  in  WRITE_ADDR_WIDTH  target row
wr_data  in  PARA_Y*DATA_WIDTH  write data
rd_valid  in  1  read request
rd_ready  out  1  read accepted when rd_valid&rd_ready
rd_addr  in  READ_ADDR_WIDTH  read row
rd_sub_addr  in  READ_ADDR_WIDTH  element offset within row
rd_data_valid  out  1  one-cycle pulse with rd_data
rd_data  out  PARA_Y*DATA_WIDTH  read result
clr_start  in  1  pulse: zero the bank
clr_busy  out  1  clear in progress
acc_err  out  1  sticky: RAM failed to report write_ready after an accumulate
ram_ena_w  out  1  RAM write enable
ram_ena_add_write  out  1  RAM accumulate select
ram_addr_write  out  WRITE_ADDR_WIDTH  RAM write row
ram_din  out  PARA_Y*DATA_WIDTH  RAM write data
ram_write_ready  in  1  RAM accumulate-complete flag
ram_ena_r  out  1  RAM read enable
ram_addr_read  out  READ_ADDR_WIDTH  RAM read row
ram_sub_addr_read  out  READ_ADDR_WIDTH  RAM read offset
ram_dout  in  PARA_Y*DATA_WIDTH  RAM read data

Behaviour:
- Reset values:
  - All outputs 0. acc_err is cleared only by rst.
  - State IDLE; rr_last=READ, so a write wins the first tie.
  - If rst asserts mid-operation, the current op is abandoned and RAM enables drop in the same cycle.
- Ready outputs:
  - wr_ready and rd_ready are combinational, asserted only in IDLE with clr_busy=0 and no clr_start that cycle.
  - At most one of them is high per cycle.
- Arbitration in IDLE, in priority order:
  1. clr_start (also accepted when sampled in any state, queued as a pending flag and served at the next IDLE).
  2. Round-robin between wr_valid and rd_valid. On a tie, grant the class not served last; a lone requester is always granted.
  - The grant updates rr_last. The accepted request's fields are latched.
- States:
  - WR: one cycle. ram_ena_w=1, ram_ena_add_write=0, latched addr/data. Then IDLE.
  - ACC1: ram_ena_w=1, ram_ena_add_write=1, addr/data held. The RAM latches operands.
  - ACC2: same outputs held. The RAM writes the sum and raises write_ready.
  - ACCCHK: enables 0. If ram_write_ready != 1, set acc_err. Then IDLE.
  - RD: ram_ena_r=1 with latched addr/sub_addr for one cycle.
  - RDCAP: capture ram_dout into rd_data, pulse rd_data_valid. Then IDLE.
  - CLR: clr_busy=1. Plain writes of all-zero data to rows 0..ROW_COUNT-1, one row per cycle, using a row counter. After the last row, clr_busy drops the next cycle and the state returns to IDLE.
- Latencies from acceptance edge:
  - Plain write: 1 cycle.
  - Accumulate: 3 cycles before the next grant.
  - Read: rd_data_valid 2 cycles after acceptance.
  - Clear: ROW_COUNT cycles.
- Ordering:
  - Operations retire strictly in grant order.
  - A read granted after a write or accumulate to the same row returns the updated value.
- ram_ena_w and ram_ena_r are never high in the same cycle.
- Address rule: wr_addr >= ROW_COUNT is still forwarded. Range checking is the requester's duty.
- A clr_start arriving while clr_busy=1 is ignored (the pending flag is not set).

Test Plan:
- rst, then wr_valid with wr_acc=0, wr_addr=2, wr_data={3C00,4000,4200} → one cycle with ram_ena_w=1, ram_ena_add_write=0, row 2; then rd_addr=2, sub=0 → rd_data={4200,4000,3C00} 2 cycles later.
- Write row 1 = {3C00,3C00,3C00}, then accumulate row 1 with {3C00,3C00,3C00} → ram_ena_add_write high exactly 2 cycles, acc_err=0; read row 1 → {4000,4000,4000}.
- Stub RAM holds write_ready=0 during an accumulate → acc_err=1 after ACCCHK and stays 1 until rst.
- wr_valid and rd_valid held high together for 4 grants → order is W,R,W,R; no cycle has ram_ena_w and ram_ena_r both high.
- clr_start during an accumulate → accumulate completes, then 7 zero writes to rows 0..6 with clr_busy=1; wr_ready=0 throughout; a read afterwards returns 0.
- Assert rst in ACC1 → the next cycle has all RAM enables 0 and state IDLE; a subsequent write proceeds normally.
